// File: rtl/player_state_packer.sv
// ---------------------------------------------------------------------------
// player_state_packer
//
// Once per frame, at a fixed raster position, takes a snapshot of every
// player channel (x, y, heading, status) and streams it out as one 45-bit
// record per channel over a valid/ready/last handshake. The snapshot is
// copied into a shadow bank, so input changes while sending do not leak into
// records that are already queued. Triggers that arrive while a snapshot is
// still in flight are dropped and counted.
//
// Record layout: {seq[7:0], id[2:0], x[10:0], y[10:0], dir[8:0], stat[2:0]}
//
// Parameters:
//   N_PLAYERS  number of player channels (1..8)
//   SNAP_H     hcount value that triggers a snapshot
//   SNAP_V     vcount value that triggers a snapshot
//
// Ports:
//   clk_in       pixel clock, rising edge
//   rst_n_in     synchronous active-low reset
//   hcount_in    current pixel on the line
//   vcount_in    current line
//   player_x_in  packed x positions, channel k at [11k+10:11k]
//   player_y_in  packed y positions, same packing
//   dir_in       packed headings (0..359), channel k at [9k+8:9k]
//   stat_in      packed status, channel k at [3k+2:3k]
//   tready_in    downstream ready
//   tvalid_out   record valid
//   tdata_out    record payload
//   tlast_out    marks the record for channel N_PLAYERS-1
//   busy_out     high while a snapshot is loading or sending
//   overrun_out  dropped-trigger count, saturating at 255
//
// Build option:
//   PACKER_CHANGE_ONLY_EN  when defined, a snapshot identical to the last
//                          one sent is discarded in LOAD (no records, seq
//                          unchanged); the first snapshot after reset is
//                          always sent.
// ---------------------------------------------------------------------------
module player_state_packer #(
  parameter int N_PLAYERS = 2,
  parameter int SNAP_H    = 1250,
  parameter int SNAP_V    = 850
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [10:0]              hcount_in,
  input  logic [9:0]               vcount_in,
  input  logic [11*N_PLAYERS-1:0]  player_x_in,
  input  logic [11*N_PLAYERS-1:0]  player_y_in,
  input  logic [9*N_PLAYERS-1:0]   dir_in,
  input  logic [3*N_PLAYERS-1:0]   stat_in,
  input  logic                     tready_in,
  output logic                     tvalid_out,
  output logic [44:0]              tdata_out,
  output logic                     tlast_out,
  output logic                     busy_out,
  output logic [7:0]               overrun_out
);

  localparam int IDX_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PLAYERS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t           state;
  logic             trig;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [7:0]       seq;
  logic             handshake;
  logic             skip_load;

  logic [10:0] in_x    [N_PLAYERS];
  logic [10:0] in_y    [N_PLAYERS];
  logic [8:0]  in_dir  [N_PLAYERS];
  logic [2:0]  in_stat [N_PLAYERS];

  logic [10:0] sh_x    [N_PLAYERS];
  logic [10:0] sh_y    [N_PLAYERS];
  logic [8:0]  sh_dir  [N_PLAYERS];
  logic [2:0]  sh_stat [N_PLAYERS];

  // Unpack the flat input buses into per-channel fields.
  genvar g;
  generate
    for (g = 0; g < N_PLAYERS; g++) begin : g_unpack
      assign in_x[g]    = player_x_in[11*g +: 11];
      assign in_y[g]    = player_y_in[11*g +: 11];
      assign in_dir[g]  = dir_in[9*g +: 9];
      assign in_stat[g] = stat_in[3*g +: 3];
    end
  endgenerate

  function automatic logic [44:0] pack_record(
    input logic [7:0]  s,
    input logic [2:0]  id,
    input logic [10:0] x,
    input logic [10:0] y,
    input logic [8:0]  d,
    input logic [2:0]  st
  );
    return {s, id, x, y, d, st};
  endfunction

  assign handshake = tvalid_out & tready_in;
  assign idx_next  = idx + IDX_W'(1);
  assign busy_out  = (state != IDLE);

  // One-cycle strobe, registered so the raster compare is off the FSM path.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      trig <= 1'b0;
    end else begin
      trig <= (hcount_in == 11'(SNAP_H)) && (vcount_in == 10'(SNAP_V));
    end
  end

  // Any trigger seen outside IDLE is dropped; this includes the cycle of the
  // final handshake, since the FSM is still in SEND then.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      overrun_out <= 8'd0;
    end else if (trig && (state != IDLE) && (overrun_out != 8'hFF)) begin
      overrun_out <= overrun_out + 8'd1;
    end
  end

`ifdef PACKER_CHANGE_ONLY_EN
  logic        have_sent;
  logic        same;
  logic [10:0] sent_x    [N_PLAYERS];
  logic [10:0] sent_y    [N_PLAYERS];
  logic [8:0]  sent_dir  [N_PLAYERS];
  logic [2:0]  sent_stat [N_PLAYERS];

  always_comb begin
    same = 1'b1;
    for (int k = 0; k < N_PLAYERS; k++) begin
      if ((in_x[k] != sent_x[k]) || (in_y[k] != sent_y[k]) ||
          (in_dir[k] != sent_dir[k]) || (in_stat[k] != sent_stat[k])) begin
        same = 1'b0;
      end
    end
  end

  // have_sent forces the first snapshot after reset out even if it matches
  // the cleared reference bank.
  assign skip_load = have_sent & same;

  // Reference bank: the last snapshot that actually produced records.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      have_sent <= 1'b0;
      for (int k = 0; k < N_PLAYERS; k++) begin
        sent_x[k]    <= '0;
        sent_y[k]    <= '0;
        sent_dir[k]  <= '0;
        sent_stat[k] <= '0;
      end
    end else if ((state == LOAD) && !skip_load) begin
      have_sent <= 1'b1;
      for (int k = 0; k < N_PLAYERS; k++) begin
        sent_x[k]    <= in_x[k];
        sent_y[k]    <= in_y[k];
        sent_dir[k]  <= in_dir[k];
        sent_stat[k] <= in_stat[k];
      end
    end
  end
`else
  assign skip_load = 1'b0;
`endif

  // Main FSM. Outputs are registered: LOAD builds record 0 straight from the
  // inputs (the same values going into the shadow bank) so tvalid is up in
  // the first SEND cycle; each later record is built from the shadow bank on
  // the handshake of the previous one, which keeps tdata stable while
  // tready is low.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      idx        <= '0;
      seq        <= 8'd0;
      tvalid_out <= 1'b0;
      tlast_out  <= 1'b0;
      tdata_out  <= '0;
      for (int k = 0; k < N_PLAYERS; k++) begin
        sh_x[k]    <= '0;
        sh_y[k]    <= '0;
        sh_dir[k]  <= '0;
        sh_stat[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            state <= LOAD;
          end
        end

        LOAD: begin
          for (int k = 0; k < N_PLAYERS; k++) begin
            sh_x[k]    <= in_x[k];
            sh_y[k]    <= in_y[k];
            sh_dir[k]  <= in_dir[k];
            sh_stat[k] <= in_stat[k];
          end
          if (skip_load) begin
            state <= IDLE;
          end else begin
            state      <= SEND;
            idx        <= '0;
            tvalid_out <= 1'b1;
            tlast_out  <= (LAST_IDX == '0);
            tdata_out  <= pack_record(seq, 3'd0, in_x[0], in_y[0],
                                      in_dir[0], in_stat[0]);
          end
        end

        SEND: begin
          if (handshake) begin
            if (tlast_out) begin
              state      <= IDLE;
              tvalid_out <= 1'b0;
              tlast_out  <= 1'b0;
              seq        <= seq + 8'd1;
            end else begin
              idx       <= idx_next;
              tlast_out <= (idx_next == LAST_IDX);
              tdata_out <= pack_record(seq, 3'(idx_next), sh_x[idx_next],
                                       sh_y[idx_next], sh_dir[idx_next],
                                       sh_stat[idx_next]);
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_state_packer.sv
// ---------------------------------------------------------------------------
// tb_player_state_packer
//
// Drives raster counters, player fields and tready, and compares the DUT
// every cycle against a transaction-level model: each accepted trigger turns
// into a queue of expected records built from the field values present at
// LOAD time; records leave the queue on handshakes. The model also tracks
// busy, seq and the saturating overrun count.
// ---------------------------------------------------------------------------
module tb_player_state_packer;

  localparam int N      = 2;
  localparam int SNAP_H = 1250;
  localparam int SNAP_V = 850;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [10:0]       hcount;
  logic [9:0]        vcount;
  logic [11*N-1:0]   x_bus;
  logic [11*N-1:0]   y_bus;
  logic [9*N-1:0]    dir_bus;
  logic [3*N-1:0]    stat_bus;
  logic              tready;
  logic              tvalid;
  logic [44:0]       tdata;
  logic              tlast;
  logic              busy;
  logic [7:0]        overrun;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [45:0] exp_q[$];
  bit          snap_open;
  bit          trig_pend;
  bit          capture_pend;
  int          m_seq;
  int          m_overrun;
`ifdef PACKER_CHANGE_ONLY_EN
  bit                               have_sent;
  logic [11*N+11*N+9*N+3*N-1:0]     last_sent;
`endif

  player_state_packer #(
    .N_PLAYERS(N),
    .SNAP_H(SNAP_H),
    .SNAP_V(SNAP_V)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .hcount_in(hcount),
    .vcount_in(vcount),
    .player_x_in(x_bus),
    .player_y_in(y_bus),
    .dir_in(dir_bus),
    .stat_in(stat_bus),
    .tready_in(tready),
    .tvalid_out(tvalid),
    .tdata_out(tdata),
    .tlast_out(tlast),
    .busy_out(busy),
    .overrun_out(overrun)
  );

  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic setChannel(input int k, input int x, input int y,
                            input int d, input int s);
    x_bus[11*k +: 11]  = 11'(x);
    y_bus[11*k +: 11]  = 11'(y);
    dir_bus[9*k +: 9]  = 9'(d);
    stat_bus[3*k +: 3] = 3'(s);
  endtask

  task automatic randomFields();
    for (int k = 0; k < N; k++) begin
      setChannel(k, $urandom_range(0, 2047), $urandom_range(0, 2047),
                 $urandom_range(0, 359), $urandom_range(0, 7));
    end
  endtask

  // Snapshot taken from whatever the bench is presenting at the LOAD edge.
  task automatic captureSnapshot();
`ifdef PACKER_CHANGE_ONLY_EN
    if (have_sent && ({x_bus, y_bus, dir_bus, stat_bus} == last_sent)) begin
      snap_open = 1'b0;
      return;
    end
    have_sent = 1'b1;
    last_sent = {x_bus, y_bus, dir_bus, stat_bus};
`endif
    for (int k = 0; k < N; k++) begin
      exp_q.push_back({(k == N - 1), 8'(m_seq), 3'(k), x_bus[11*k +: 11],
                       y_bus[11*k +: 11], dir_bus[9*k +: 9], stat_bus[3*k +: 3]});
    end
  endtask

  // One clock: present inputs, advance the model across the edge, then
  // compare the DUT just after the edge.
  task automatic applyStimulus(input logic [10:0] h, input logic [9:0] v,
                               input bit rdy, input bit rst_active);
    bit trig_now;
    bit cap_now;
    bit open_now;
    bit popped_last;
    hcount = h;
    vcount = v;
    tready = rdy;
    rst_n  = !rst_active;
    if (rst_active) begin
      exp_q.delete();
      snap_open    = 1'b0;
      trig_pend    = 1'b0;
      capture_pend = 1'b0;
      m_seq        = 0;
      m_overrun    = 0;
`ifdef PACKER_CHANGE_ONLY_EN
      have_sent    = 1'b0;
`endif
    end else begin
      trig_now     = trig_pend;
      cap_now      = capture_pend;
      open_now     = snap_open;
      capture_pend = 1'b0;
      if ((exp_q.size() > 0) && rdy) begin
        popped_last = exp_q[0][45];
        void'(exp_q.pop_front());
        if (popped_last) begin
          snap_open = 1'b0;
          m_seq     = (m_seq + 1) % 256;
        end
      end
      if (cap_now) begin
        captureSnapshot();
      end
      if (trig_now) begin
        if (open_now) begin
          if (m_overrun < 255) m_overrun++;
        end else begin
          snap_open    = 1'b1;
          capture_pend = 1'b1;
        end
      end
      trig_pend = (h == 11'(SNAP_H)) && (v == 10'(SNAP_V));
    end
    @(posedge clk);
    #1;
    checkOutput("tvalid", 64'(tvalid), 64'(exp_q.size() > 0));
    checkOutput("busy", 64'(busy), 64'(snap_open));
    checkOutput("overrun", 64'(overrun), 64'(m_overrun));
    if (exp_q.size() > 0) begin
      checkOutput("tdata", 64'(tdata), 64'(exp_q[0][44:0]));
      checkOutput("tlast", 64'(tlast), 64'(exp_q[0][45]));
    end
  endtask

  task automatic idleCycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(11'd0, 10'd0, rdy, 1'b0);
  endtask

  task automatic pulseTrigger(input bit rdy);
    applyStimulus(11'(SNAP_H), 10'(SNAP_V), rdy, 1'b0);
  endtask

  int          r;
  logic [10:0] h;
  logic [9:0]  v;

  initial begin
    rst_n    = 1'b0;
    hcount   = '0;
    vcount   = '0;
    tready   = 1'b0;
    x_bus    = '0;
    y_bus    = '0;
    dir_bus  = '0;
    stat_bus = '0;

    // Reset state
    applyStimulus(11'd0, 10'd0, 1'b0, 1'b1);
    applyStimulus(11'd0, 10'd0, 1'b0, 1'b1);
    checkOutput("reset_tvalid", 64'(tvalid), 64'd0);
    checkOutput("reset_tlast", 64'(tlast), 64'd0);
    checkOutput("reset_tdata", 64'(tdata), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_overrun", 64'(overrun), 64'd0);
    idleCycles(3, 1'b1);

    // Known two-channel snapshot, tready high throughout
    setChannel(0, 100, 200, 270, 1);
    setChannel(1, 5, 6, 90, 2);
    pulseTrigger(1'b1);
    idleCycles(2, 1'b1);
    checkOutput("first_rec", 64'(tdata),
                64'({8'd0, 3'd0, 11'd100, 11'd200, 9'd270, 3'd1}));
    idleCycles(1, 1'b1);
    checkOutput("second_rec", 64'(tdata),
                64'({8'd0, 3'd1, 11'd5, 11'd6, 9'd90, 3'd2}));
    checkOutput("second_last", 64'(tlast), 64'd1);
    idleCycles(4, 1'b1);

    // Backpressure: tready low for 5 cycles once tvalid is up
    randomFields();
    pulseTrigger(1'b0);
    idleCycles(2, 1'b0);
    idleCycles(5, 1'b0);
    idleCycles(6, 1'b1);

    // Inputs changed while sending must not reach queued records
    randomFields();
    pulseTrigger(1'b0);
    idleCycles(2, 1'b0);
    for (int k = 0; k < N; k++) x_bus[11*k +: 11] = 11'd999;
    idleCycles(3, 1'b0);
    idleCycles(6, 1'b1);

    // Randomized traffic with partial raster matches and rare resets
    for (int c = 0; c < 2500; c++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        h = 11'(SNAP_H);
        v = 10'(SNAP_V);
      end else if (r < 10) begin
        h = 11'(SNAP_H);
        v = 10'($urandom_range(0, SNAP_V - 1));
      end else begin
        h = 11'($urandom_range(0, SNAP_H - 1));
        v = 10'(SNAP_V);
      end
      if ($urandom_range(0, 3) == 0) randomFields();
      applyStimulus(h, v, ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 499) == 0));
    end
    idleCycles(20, 1'b1);

    // Stalled output: 300 triggers, overrun must saturate
    randomFields();
    for (int t = 0; t < 300; t++) begin
      pulseTrigger(1'b0);
      idleCycles(1, 1'b0);
    end
    checkOutput("overrun_sat", 64'(overrun), 64'd255);
    idleCycles(10, 1'b1);
    checkOutput("overrun_hold", 64'(overrun), 64'd255);

    // Reset in the middle of SEND
    randomFields();
    pulseTrigger(1'b0);
    idleCycles(3, 1'b0);
    applyStimulus(11'd0, 10'd0, 1'b0, 1'b1);
    checkOutput("midrst_tvalid", 64'(tvalid), 64'd0);
    checkOutput("midrst_tdata", 64'(tdata), 64'd0);
    checkOutput("midrst_overrun", 64'(overrun), 64'd0);
    idleCycles(2, 1'b1);
    randomFields();
    pulseTrigger(1'b1);
    idleCycles(2, 1'b1);
    checkOutput("post_rst_seq", 64'(tdata[44:37]), 64'd0);
    idleCycles(4, 1'b1);

    // Repeated snapshot with unchanged inputs, then a changed one
    randomFields();
    pulseTrigger(1'b1);
    idleCycles(6, 1'b1);
    pulseTrigger(1'b1);
    idleCycles(6, 1'b1);
    stat_bus[2:0] = stat_bus[2:0] + 3'd1;
    pulseTrigger(1'b1);
    idleCycles(6, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
